// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding scoreboard.
package pipe_pkg;

  localparam int unsigned REGW        = 5;
  localparam int unsigned MEM_LAT_MAX = 4;
  localparam int unsigned FWD_RF      = 0;

  // One in-flight instruction as seen by the hazard logic.
  typedef struct packed {
    logic            valid;
    logic            regwrite;
    logic            is_load;
    logic [REGW-1:0] rd;
  } slot_t;

  function automatic int unsigned depth_of(input int unsigned mem_lat);
    return mem_lat + 2;
  endfunction

endpackage

// File: rtl/sb_match.sv
// Compares one in-flight slot against one source operand.
// POS is the pipeline position the slot occupies when the consumer sits in EX.
module sb_match
  import pipe_pkg::*;
#(
  parameter int unsigned POS     = 1,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic            valid_i,
  input  logic            regwrite_i,
  input  logic            is_load_i,
  input  logic [REGW-1:0] rd_i,
  input  logic [REGW-1:0] src_i,
  input  logic            use_i,
  output logic            hit_o,
  output logic            ready_o
);

  localparam bit LOAD_OK = (POS >= MEM_LAT + 1);

  always_comb begin
    hit_o   = valid_i & regwrite_i & (rd_i != '0) & use_i & (rd_i == src_i);
    ready_o = hit_o & (~is_load_i | LOAD_OK);
  end

endmodule

// File: rtl/pipe_scoreboard.sv
// Hazard/forwarding controller: tracks in-flight writes, raises load-use
// stalls, selects EX operand forwarding sources and counts stall cycles.
module pipe_scoreboard
  import pipe_pkg::*;
#(
  parameter  int unsigned MEM_LAT = 1,
  parameter  int unsigned CNTW    = 32,
  localparam int unsigned DEPTH   = MEM_LAT + 2,
  localparam int unsigned SELW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            id_valid,
  input  logic [REGW-1:0] id_rs1,
  input  logic [REGW-1:0] id_rs2,
  input  logic            id_use_rs1,
  input  logic            id_use_rs2,
  input  logic [REGW-1:0] id_rd,
  input  logic            id_regwrite,
  input  logic            id_is_load,
  input  logic            flush,
  output logic            stall,
  output logic            bubble,
  output logic [SELW-1:0] fwd_a_sel,
  output logic [SELW-1:0] fwd_b_sel,
  output logic [CNTW-1:0] stall_cycles
);

  slot_t [DEPTH-1:0] slot_q, slot_d;
  logic [REGW-1:0]   ex_rs1_q, ex_rs1_d;
  logic [REGW-1:0]   ex_rs2_q, ex_rs2_d;
  logic              ex_use1_q, ex_use1_d;
  logic              ex_use2_q, ex_use2_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;

  logic [MEM_LAT-1:0] id_hit1, id_rdy1, id_hit2, id_rdy2;
  logic [DEPTH-1:1]   ex_hit_a, ex_rdy_a, ex_hit_b, ex_rdy_b;
  logic               stall_c;
  logic               insert_c;

  // ID sources vs slots whose load data would still be late if ID advanced now.
  for (genvar k = 0; k < MEM_LAT; k++) begin : g_id
    sb_match #(.POS(k + 1), .MEM_LAT(MEM_LAT)) u_rs1 (
      .valid_i   (slot_q[k].valid),
      .regwrite_i(slot_q[k].regwrite),
      .is_load_i (slot_q[k].is_load),
      .rd_i      (slot_q[k].rd),
      .src_i     (id_rs1),
      .use_i     (id_use_rs1),
      .hit_o     (id_hit1[k]),
      .ready_o   (id_rdy1[k])
    );
    sb_match #(.POS(k + 1), .MEM_LAT(MEM_LAT)) u_rs2 (
      .valid_i   (slot_q[k].valid),
      .regwrite_i(slot_q[k].regwrite),
      .is_load_i (slot_q[k].is_load),
      .rd_i      (slot_q[k].rd),
      .src_i     (id_rs2),
      .use_i     (id_use_rs2),
      .hit_o     (id_hit2[k]),
      .ready_o   (id_rdy2[k])
    );
  end

  // EX operands (held in slot0) vs every older slot that can forward.
  for (genvar k = 1; k < DEPTH; k++) begin : g_ex
    sb_match #(.POS(k), .MEM_LAT(MEM_LAT)) u_rs1 (
      .valid_i   (slot_q[k].valid),
      .regwrite_i(slot_q[k].regwrite),
      .is_load_i (slot_q[k].is_load),
      .rd_i      (slot_q[k].rd),
      .src_i     (ex_rs1_q),
      .use_i     (ex_use1_q),
      .hit_o     (ex_hit_a[k]),
      .ready_o   (ex_rdy_a[k])
    );
    sb_match #(.POS(k), .MEM_LAT(MEM_LAT)) u_rs2 (
      .valid_i   (slot_q[k].valid),
      .regwrite_i(slot_q[k].regwrite),
      .is_load_i (slot_q[k].is_load),
      .rd_i      (slot_q[k].rd),
      .src_i     (ex_rs2_q),
      .use_i     (ex_use2_q),
      .hit_o     (ex_hit_b[k]),
      .ready_o   (ex_rdy_b[k])
    );
  end

  // Youngest matching writer wins; a not-yet-ready load falls back to the regfile.
  function automatic logic [SELW-1:0] youngest(input logic [DEPTH-1:1] hit,
                                               input logic [DEPTH-1:1] rdy);
    logic [SELW-1:0] sel;
    sel = SELW'(FWD_RF);
    for (int k = int'(DEPTH) - 1; k >= 1; k--) begin
      if (hit[k]) sel = rdy[k] ? SELW'(k) : SELW'(FWD_RF);
    end
    return sel;
  endfunction

  always_comb begin
    stall_c  = ~flush & id_valid & (|((id_hit1 & ~id_rdy1) | (id_hit2 & ~id_rdy2)));
    insert_c = id_valid & ~stall_c & ~flush;
  end

  always_comb begin
    stall     = stall_c;
    bubble    = ~insert_c;
    fwd_a_sel = youngest(ex_hit_a, ex_rdy_a);
    fwd_b_sel = youngest(ex_hit_b, ex_rdy_b);
    stall_cycles = cnt_q;
  end

  // Shift every slot one stage; slot0 takes the ID instruction or a bubble.
  always_comb begin
    slot_d    = '0;
    ex_rs1_d  = '0;
    ex_rs2_d  = '0;
    ex_use1_d = 1'b0;
    ex_use2_d = 1'b0;
    for (int k = 1; k < int'(DEPTH); k++) begin
      slot_d[k] = slot_q[k-1];
    end
    if (insert_c) begin
      slot_d[0].valid    = 1'b1;
      slot_d[0].regwrite = id_regwrite;
      slot_d[0].is_load  = id_is_load;
      slot_d[0].rd       = id_rd;
      ex_rs1_d           = id_rs1;
      ex_rs2_d           = id_rs2;
      ex_use1_d          = id_use_rs1;
      ex_use2_d          = id_use_rs2;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (stall_c && (cnt_q != {CNTW{1'b1}})) cnt_d = cnt_q + CNTW'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      slot_q    <= '0;
      ex_rs1_q  <= '0;
      ex_rs2_q  <= '0;
      ex_use1_q <= 1'b0;
      ex_use2_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      slot_q    <= slot_d;
      ex_rs1_q  <= ex_rs1_d;
      ex_rs2_q  <= ex_rs2_d;
      ex_use1_q <= ex_use1_d;
      ex_use2_q <= ex_use2_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_scoreboard.sv
// Directed and random checks of two scoreboard configurations against an
// instruction-level reference model.
module tb_pipe_scoreboard;
  import pipe_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset, id_valid, id_use_rs1, id_use_rs2, id_regwrite, id_is_load, flush;
  logic [REGW-1:0] id_rs1, id_rs2, id_rd;

  logic        a_stall, a_bubble;
  logic [1:0]  a_fa, a_fb;
  logic [31:0] a_cnt;
  logic        b_stall, b_bubble;
  logic [2:0]  b_fa, b_fb;
  logic [3:0]  b_cnt;

  int vectors = 0;
  int miscompares = 0;

  pipe_scoreboard #(.MEM_LAT(1), .CNTW(32)) u_dut_a (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_is_load(id_is_load), .flush(flush),
    .stall(a_stall), .bubble(a_bubble), .fwd_a_sel(a_fa), .fwd_b_sel(a_fb),
    .stall_cycles(a_cnt)
  );

  pipe_scoreboard #(.MEM_LAT(3), .CNTW(4)) u_dut_b (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_is_load(id_is_load), .flush(flush),
    .stall(b_stall), .bubble(b_bubble), .fwd_a_sel(b_fa), .fwd_b_sel(b_fb),
    .stall_cycles(b_cnt)
  );

  // Reference model: per configuration, the instructions at each age since entering EX.
  typedef struct {
    bit v, rw, ld, u1, u2;
    int rd, rs1, rs2;
  } rec_t;

  rec_t   mslot[2][8];
  longint mcnt[2];
  bit     mst[2];

  function automatic int lat(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic longint cmax(input int d);
    return (d == 0) ? 64'hFFFF_FFFF : 15;
  endfunction

  function automatic bit writer(input rec_t r);
    return r.v && r.rw && (r.rd != 0);
  endfunction

  function automatic bit m_stall(input int d);
    if (flush || !id_valid) return 1'b0;
    for (int k = 0; k < lat(d); k++) begin
      if (writer(mslot[d][k]) && mslot[d][k].ld &&
          ((id_use_rs1 && int'(id_rs1) == mslot[d][k].rd) ||
           (id_use_rs2 && int'(id_rs2) == mslot[d][k].rd)))
        return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic int m_fwd(input int d, input bit second);
    int rs;
    bit u;
    rs = second ? mslot[d][0].rs2 : mslot[d][0].rs1;
    u  = second ? mslot[d][0].u2  : mslot[d][0].u1;
    if (!u) return 0;
    for (int k = 1; k <= lat(d) + 1; k++) begin
      if (writer(mslot[d][k]) && mslot[d][k].rd == rs) return k;
    end
    return 0;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    mst[0] = m_stall(0);
    mst[1] = m_stall(1);
    chk("a_stall",  a_stall,  mst[0]);
    chk("a_bubble", a_bubble, mst[0] || flush || !id_valid);
    chk("a_fwd_a",  a_fa,     m_fwd(0, 1'b0));
    chk("a_fwd_b",  a_fb,     m_fwd(0, 1'b1));
    chk("a_cnt",    a_cnt,    mcnt[0]);
    chk("b_stall",  b_stall,  mst[1]);
    chk("b_bubble", b_bubble, mst[1] || flush || !id_valid);
    chk("b_fwd_a",  b_fa,     m_fwd(1, 1'b0));
    chk("b_fwd_b",  b_fb,     m_fwd(1, 1'b1));
    chk("b_cnt",    b_cnt,    mcnt[1]);
    if (a_fa != 0 && mslot[0][a_fa].ld) chk("a_load_slot_a", a_fa >= 2, 1);
    if (a_fb != 0 && mslot[0][a_fb].ld) chk("a_load_slot_b", a_fb >= 2, 1);
    if (b_fa != 0 && mslot[1][b_fa].ld) chk("b_load_slot_a", b_fa >= 4, 1);
    if (b_fb != 0 && mslot[1][b_fb].ld) chk("b_load_slot_b", b_fb >= 4, 1);
  endtask

  task automatic m_edge();
    rec_t r;
    for (int d = 0; d < 2; d++) begin
      if (!reset) begin
        for (int k = 0; k < 8; k++) mslot[d][k] = '{default: 0};
        mcnt[d] = 0;
      end else begin
        if (mst[d] && mcnt[d] < cmax(d)) mcnt[d]++;
        for (int k = lat(d) + 1; k >= 1; k--) mslot[d][k] = mslot[d][k-1];
        r = '{default: 0};
        if (id_valid && !mst[d] && !flush) begin
          r.v = 1'b1; r.rw = id_regwrite; r.ld = id_is_load; r.rd = int'(id_rd);
          r.rs1 = int'(id_rs1); r.rs2 = int'(id_rs2); r.u1 = id_use_rs1; r.u2 = id_use_rs2;
        end
        mslot[d][0] = r;
      end
    end
  endtask

  task automatic drive(input bit v, input int rd, input bit rw, input bit ld,
                       input int rs1, input bit u1, input int rs2, input bit u2,
                       input bit fl, input bit rst_n);
    @(negedge clk);
    id_valid = v; id_rd = REGW'(rd); id_regwrite = rw; id_is_load = ld;
    id_rs1 = REGW'(rs1); id_use_rs1 = u1; id_rs2 = REGW'(rs2); id_use_rs2 = u2;
    flush = fl; reset = rst_n;
    #1;
    check_all();
  endtask

  task automatic tick();
    @(posedge clk);
    m_edge();
  endtask

  task automatic nops(input int n);
    for (int i = 0; i < n; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      tick();
    end
  endtask

  initial begin
    reset = 1'b0; id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; id_regwrite = 1'b0; id_is_load = 1'b0; flush = 1'b0;
    mst[0] = 1'b0; mst[1] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    m_edge();

    // reset state
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("rst_a_bubble", a_bubble, 1); chk("rst_b_cnt", b_cnt, 0); chk("rst_a_fa", a_fa, 0);
    tick();

    // lw x5 then add x6,x5,x1 held in ID
    drive(1, 5, 1, 1, 1, 1, 0, 0, 0, 1); chk("lu_a_nostall", a_stall, 0); tick();
    drive(1, 6, 1, 0, 5, 1, 1, 1, 0, 1); chk("lu1_a_stall", a_stall, 1); chk("lu1_b_stall", b_stall, 1); tick();
    drive(1, 6, 1, 0, 5, 1, 1, 1, 0, 1); chk("lu2_a_stall", a_stall, 0); chk("lu2_b_stall", b_stall, 1); tick();
    drive(1, 6, 1, 0, 5, 1, 1, 1, 0, 1); chk("lu3_a_fwd", a_fa, 2); chk("lu3_a_cnt", a_cnt, 1);
    chk("lu3_b_stall", b_stall, 1); tick();
    drive(1, 6, 1, 0, 5, 1, 1, 1, 0, 1); chk("lu4_b_stall", b_stall, 0); chk("lu4_b_cnt", b_cnt, 3); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1); chk("lu5_b_fwd", b_fa, 4); tick();
    nops(6);

    // add x3; add x3; sub x4,x3,x3
    drive(1, 3, 1, 0, 1, 1, 2, 1, 0, 1); tick();
    drive(1, 3, 1, 0, 1, 1, 2, 1, 0, 1); tick();
    drive(1, 4, 1, 0, 3, 1, 3, 1, 0, 1); chk("yng_a_stall", a_stall, 0); chk("yng_b_stall", b_stall, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("yng_a_fa", a_fa, 1); chk("yng_a_fb", a_fb, 1); chk("yng_b_fa", b_fa, 1); chk("yng_b_fb", b_fb, 1);
    tick();
    nops(6);

    // x0 destination and unused rs2
    drive(1, 0, 1, 1, 1, 1, 0, 0, 0, 1); tick();
    drive(1, 1, 1, 0, 0, 1, 0, 1, 0, 1); chk("x0_a_stall", a_stall, 0); chk("x0_b_stall", b_stall, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1); chk("x0_a_fa", a_fa, 0); chk("x0_a_fb", a_fb, 0); tick();
    drive(1, 5, 1, 1, 1, 1, 0, 0, 0, 1); tick();
    drive(1, 7, 1, 0, 2, 1, 5, 0, 0, 1); chk("use2_a_stall", a_stall, 0); chk("use2_b_stall", b_stall, 0); tick();
    nops(6);

    // flush during a load-use stall
    drive(1, 5, 1, 1, 1, 1, 0, 0, 0, 1); tick();
    drive(1, 6, 1, 0, 5, 1, 1, 1, 1, 1);
    chk("fl_a_stall", a_stall, 0); chk("fl_a_bubble", a_bubble, 1);
    chk("fl_b_stall", b_stall, 0); chk("fl_b_bubble", b_bubble, 1); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1); chk("fl_a_fa", a_fa, 0); chk("fl_b_fa", b_fa, 0); tick();
    nops(6);

    // reset while stalled with three slots occupied
    drive(1, 1, 1, 0, 2, 1, 2, 1, 0, 1); tick();
    drive(1, 2, 1, 0, 3, 1, 3, 1, 0, 1); tick();
    drive(1, 5, 1, 1, 1, 1, 0, 0, 0, 1); tick();
    drive(1, 6, 1, 0, 5, 1, 1, 1, 0, 0); chk("mr_b_stall", b_stall, 1); tick();
    drive(1, 6, 1, 0, 5, 1, 1, 1, 0, 1);
    chk("mr_b_stall_after", b_stall, 0); chk("mr_b_cnt", b_cnt, 0); chk("mr_a_cnt", a_cnt, 0);
    chk("mr_b_fa", b_fa, 0); chk("mr_b_fb", b_fb, 0); chk("mr_a_fa", a_fa, 0);
    tick();
    nops(6);

    // saturate the 4-bit counter
    for (int i = 0; i < 8; i++) begin
      drive(1, 5, 1, 1, 1, 1, 0, 0, 0, 1); tick();
      for (int j = 0; j < 4; j++) begin
        drive(1, 6, 1, 0, 5, 1, 1, 1, 0, 1); tick();
      end
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1); chk("sat_b_cnt", b_cnt, 15); tick();

    // random traffic over a small register set to provoke hazards
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 7) != 0, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            $urandom_range(0, 9) == 0, $urandom_range(0, 63) != 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
